// File: rtl/nes_cpu_bus_capture.sv
`default_nettype none
// ============================================================================
//  Module   : nes_cpu_bus_capture
//  Purpose  : Samples the asynchronous NES CPU bus in the SYSCLK domain and
//             turns completed CPU cycles into register-write FIFO entries and
//             read strobes. Optional statistics counters: CAPTURE_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module nes_cpu_bus_capture #(
    parameter int          SYNC_STAGES = 2,
    parameter int          SAMPLE_DLY  = 3,
    parameter int          QDEPTH_LOG2 = 2,
    parameter logic [14:0] WIN_LO      = 15'h4020,
    parameter logic [14:0] WIN_HI      = 15'h405F
) (
    input  logic                   SYSCLK,
    input  logic                   RST,
    input  logic                   M2,
    input  logic                   nROMSEL,
    input  logic [14:0]            CPU_A,
    input  logic [7:0]             CPU_D,
    input  logic                   CPU_RW,
    output logic                   WR_VALID,
    input  logic                   WR_READY,
    output logic [6:0]             WR_OFS,
    output logic [7:0]             WR_DATA,
    output logic                   RD_STB,
    output logic                   RD_ROMHI,
    output logic [QDEPTH_LOG2:0]   Q_LEVEL,
    output logic [7:0]             DROP_CNT,
    output logic [7:0]             SHORT_CNT
);

    localparam int                 C_DEPTH      = 1 << QDEPTH_LOG2;
    localparam logic [3:0]         C_SAMPLE_DLY = SAMPLE_DLY[3:0];
    localparam logic [QDEPTH_LOG2:0] C_FULL     = C_DEPTH[QDEPTH_LOG2:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_HELD   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   w_m2s;
    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   snap_nrom_q, snap_nrom_d;
    logic                   snap_rw_q, snap_rw_d;
    logic [14:0]            snap_a_q, snap_a_d;
    logic [7:0]             snap_dat_q, snap_dat_d;
    logic                   rd_stb_q, rd_stb_d;
    logic                   rd_romhi_q, rd_romhi_d;

    logic [QDEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [QDEPTH_LOG2:0]   level_q, level_d;
    logic [14:0]            mem_q [C_DEPTH];
    logic                   w_push, w_pop, w_full, w_empty, w_wr_en;

    assign w_m2s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        snap_nrom_d = snap_nrom_q;
        snap_rw_d   = snap_rw_q;
        snap_a_d    = snap_a_q;
        snap_dat_d  = snap_dat_q;
        rd_stb_d    = 1'b0;
        rd_romhi_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_m2s) begin
                    cnt_d   = 4'd1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_m2s) begin
                    state_d = S_IDLE;
                end else if (cnt_q == C_SAMPLE_DLY) begin
                    snap_nrom_d = nROMSEL;
                    snap_rw_d   = CPU_RW;
                    snap_a_d    = CPU_A;
                    snap_dat_d  = CPU_D;
                    state_d     = S_HELD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HELD: begin
                // Read strobe is registered so it is high for the whole COMMIT cycle.
                if (!w_m2s) begin
                    state_d    = S_COMMIT;
                    rd_stb_d   = snap_rw_q;
                    rd_romhi_d = snap_rw_q & ~snap_nrom_q & snap_a_q[14];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign w_push  = (state_q == S_COMMIT) && !snap_rw_q && snap_nrom_q &&
                     (snap_a_q >= WIN_LO) && (snap_a_q <= WIN_HI);
    assign w_empty = (level_q == '0);
    assign w_full  = (level_q == C_FULL);
    assign w_pop   = WR_READY && !w_empty;
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (w_wr_en) wptr_d = wptr_q + 1'b1;
        if (w_pop)   rptr_d = rptr_q + 1'b1;
        case ({w_wr_en, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            sync_q      <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            snap_nrom_q <= 1'b1;
            snap_rw_q   <= 1'b1;
            snap_a_q    <= '0;
            snap_dat_q  <= '0;
            rd_stb_q    <= 1'b0;
            rd_romhi_q  <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], M2};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snap_nrom_q <= snap_nrom_d;
            snap_rw_q   <= snap_rw_d;
            snap_a_q    <= snap_a_d;
            snap_dat_q  <= snap_dat_d;
            rd_stb_q    <= rd_stb_d;
            rd_romhi_q  <= rd_romhi_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
        end
    end

    // Window is at most 128 bytes, so the low address bits give the offset.
    always_ff @(posedge SYSCLK) begin
        if (w_wr_en) mem_q[wptr_q] <= {snap_a_q[6:0] - WIN_LO[6:0], snap_dat_q};
    end

    assign WR_VALID = !w_empty;
    assign WR_OFS   = w_empty ? 7'd0 : mem_q[rptr_q][14:8];
    assign WR_DATA  = w_empty ? 8'd0 : mem_q[rptr_q][7:0];
    assign RD_STB   = rd_stb_q;
    assign RD_ROMHI = rd_romhi_q;
    assign Q_LEVEL  = level_q;

`ifdef CAPTURE_STATS_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [7:0] short_cnt_q, short_cnt_d;
    logic       w_drop, w_short;

    assign w_drop  = w_push && w_full && !w_pop;
    assign w_short = (state_q == S_WAIT) && !w_m2s;

    always_comb begin
        drop_cnt_d  = drop_cnt_q;
        short_cnt_d = short_cnt_q;
        if (w_drop && (drop_cnt_q != 8'hFF))   drop_cnt_d  = drop_cnt_q + 8'd1;
        if (w_short && (short_cnt_q != 8'hFF)) short_cnt_d = short_cnt_q + 8'd1;
    end

    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            drop_cnt_q  <= '0;
            short_cnt_q <= '0;
        end else begin
            drop_cnt_q  <= drop_cnt_d;
            short_cnt_q <= short_cnt_d;
        end
    end

    assign DROP_CNT  = drop_cnt_q;
    assign SHORT_CNT = short_cnt_q;
`else
    assign DROP_CNT  = 8'h00;
    assign SHORT_CNT = 8'h00;
`endif

endmodule
`default_nettype wire

// File: doc/nes_cpu_bus_capture.md
Name: nes_cpu_bus_capture

Overview:
- Front-end stage that samples the asynchronous NES expansion CPU bus (M2, nROMSEL, CPU_A, CPU_D, CPU_RW) in the SYSCLK domain.
- Converts each completed CPU cycle into clean single-cycle events and feeds the MMU register file downstream.
- Register-window writes ($4020-$405F) are queued in a small FIFO with a valid/ready handshake.
- CPU reads produce a one-cycle strobe that the unlock sequencer consumes.

Parameters:
- SYNC_STAGES, 2, flops in the M2 synchroniser chain (min 2).
- SAMPLE_DLY, 3, SYSCLK cycles after synchronised M2 rises before the bus snapshot is taken (1..15).
- QDEPTH_LOG2, 2, log2 of write FIFO depth (depth 4 by default).
- WIN_LO, 15'h4020, lowest CPU_A captured as a register write.
- WIN_HI, 15'h405F, highest CPU_A captured as a register write.

Ports:
- SYSCLK  in  1  system clock; all state on rising edge.
- RST  in  1  asynchronous active-high reset.
- M2  in  1  raw CPU phi2, asynchronous to SYSCLK.
- nROMSEL  in  1  raw cartridge ROM select, active low.
- CPU_A  in  15  raw CPU address A14..A0.
- CPU_D  in  8  raw CPU data bus.
- CPU_RW  in  1  raw CPU R/W (1 = read).
- WR_VALID  out  1  FIFO head holds a captured write.
- WR_READY  in  1  consumer accepts the head this cycle.
- WR_OFS  out  7  head address minus WIN_LO.
- WR_DATA  out  8  head data.
- RD_STB  out  1  one-cycle pulse per completed CPU read cycle.
- RD_ROMHI  out  1  qualifies RD_STB: read had nROMSEL=0 and A14=1 ($C000-$FFFF).
- Q_LEVEL  out  QDEPTH_LOG2+1  FIFO occupancy.
- DROP_CNT  out  8  writes lost to a full FIFO (saturating).
- SHORT_CNT  out  8  M2 high phases too short to sample (saturating).

Behaviour:
- Reset (asynchronous, RST=1): synchroniser cleared to 0, FSM in IDLE, FIFO empty.
  - Outputs: WR_VALID=0, WR_OFS=0, WR_DATA=0, RD_STB=0, RD_ROMHI=0, Q_LEVEL=0, DROP_CNT=0, SHORT_CNT=0.
- M2 passes through SYNC_STAGES flops to give M2S. nROMSEL/A/D/RW are not synchronised; they are captured only while M2S has been stable high.
- FSM:
  - IDLE: wait for M2S=1, then load cnt=1 and go to WAIT.
  - WAIT: if M2S=0, go to IDLE and increment SHORT_CNT. Else if cnt==SAMPLE_DLY, take a snapshot {nROMSEL, A, D, RW} and go to HELD. Else cnt++.
  - HELD: on M2S=0, go to COMMIT.
  - COMMIT (1 cycle): classify the snapshot, then go to IDLE.
- Classification in COMMIT:
  - Write: RW=0, nROMSEL=1, WIN_LO<=A<=WIN_HI. Push {A-WIN_LO, D}.
  - Read: RW=1. Assert RD_STB for exactly this cycle; RD_ROMHI = !nROMSEL && A[14].
  - Any other cycle is ignored.
- Event latency: RD_STB and the push occur SYNC_STAGES+1 SYSCLK cycles after the raw M2 falling edge.
  - A pushed entry is visible on WR_VALID on the following cycle.
- FIFO:
  - First-word-fall-through. WR_OFS/WR_DATA are valid whenever WR_VALID=1 and hold until WR_VALID && WR_READY.
  - Pointers wrap modulo 2^QDEPTH_LOG2.
  - Q_LEVEL counts 0..2^QDEPTH_LOG2.
- Full FIFO:
  - Push without a pop: the write is discarded and DROP_CNT increments.
  - Push and pop in the same cycle: the push is accepted, with no drop.
- Empty FIFO: WR_READY is ignored and the pointers do not move.
- Counters saturate at 8'hFF; no wrap.
- RST asserted mid-cycle discards the snapshot and all queued entries.
- Once RST deasserts, the first M2 high phase that is already in progress counts as a fresh phase. It is subject to the short-phase rule only if it then falls before SAMPLE_DLY.
- Requirement on the system: SYSCLK >= (SYNC_STAGES+SAMPLE_DLY+2) x M2 frequency.

Optional Feature:
- Macro CAPTURE_STATS_EN.
- Defined: DROP_CNT and SHORT_CNT count as described above.
- Undefined: both counters are removed and the ports are tied to 8'h00. All other behaviour is unchanged.

Test Plan:
- Reset, then CPU write $402B<-8'hA5 (RW=0, nROMSEL=1, M2 high 12 SYSCLKs): WR_VALID=1, WR_OFS=7'h0B, WR_DATA=8'hA5, Q_LEVEL=1. WR_READY=1 for one cycle -> Q_LEVEL=0, WR_VALID=0.
- Writes to $401F and $4060, and a read from $4020: no push. The read gives one RD_STB with RD_ROMHI=0.
- Three reads at $FFFC/$FFFD/$C000 (nROMSEL=0, A14=1): three RD_STB pulses, each with RD_ROMHI=1. A read at $8000 gives RD_ROMHI=0.
- Five writes $4030..$4034 with WR_READY=0: Q_LEVEL=4, DROP_CNT=1, and the head is ofs 7'h10. Then a sixth write with WR_READY=1 at commit: accepted, DROP_CNT stays 1.
- M2 high for only 2 SYSCLKs (SAMPLE_DLY=3): no event, SHORT_CNT=1. With CAPTURE_STATS_EN undefined: SHORT_CNT=0.
- Assert RST while in HELD with 2 queued entries: all outputs return to their reset values immediately. After release, the next complete write is the only entry in the FIFO.
